// File: rtl/tick_pwm_pkg.sv
// Shared constants for the tick-driven PWM generator: tick source encodings and build defaults.
package tick_pwm_pkg;

  localparam int unsigned TPG_W          = 8;
  localparam int unsigned TPG_DEF_PERIOD = 7;
  localparam int unsigned TPG_DEF_DUTY   = 4;

  localparam logic [1:0] DIV_SEL_CLK = 2'd0;
  localparam logic [1:0] DIV_SEL_2   = 2'd1;
  localparam logic [1:0] DIV_SEL_4   = 2'd2;
  localparam logic [1:0] DIV_SEL_8   = 2'd3;

endpackage

// File: rtl/tick_sel_edge.sv
// Selects one divided-rate input and turns its rising edges into single-clk ticks.
module tick_sel_edge
  import tick_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       divideby2,
  input  logic       divideby4,
  input  logic       divideby8,
  input  logic [1:0] div_sel,
  output logic       tick
);

  logic prev_2;
  logic prev_4;
  logic prev_8;

  // All three histories run continuously so a source switch never sees a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_2 <= 1'b0;
      prev_4 <= 1'b0;
      prev_8 <= 1'b0;
    end else begin
      prev_2 <= divideby2;
      prev_4 <= divideby4;
      prev_8 <= divideby8;
    end
  end

  always_comb begin
    tick = 1'b1;
    case (div_sel)
      DIV_SEL_CLK: tick = 1'b1;
      DIV_SEL_2:   tick = divideby2 & ~prev_2;
      DIV_SEL_4:   tick = divideby4 & ~prev_4;
      DIV_SEL_8:   tick = divideby8 & ~prev_8;
      default:     tick = 1'b1;
    endcase
  end

endmodule

// File: rtl/tick_pwm_gen.sv
// Tick-paced PWM with double-buffered period/duty that switch over only at a period boundary.
// Optional build macro PWM_DONE_PULSE_EN adds the period_done wrap pulse output.
module tick_pwm_gen
  import tick_pwm_pkg::*;
#(
  parameter int unsigned W          = TPG_W,
  parameter int unsigned DEF_PERIOD = TPG_DEF_PERIOD,
  parameter int unsigned DEF_DUTY   = TPG_DEF_DUTY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         divideby2,
  input  logic         divideby4,
  input  logic         divideby8,
  input  logic         en,
  input  logic [1:0]   div_sel,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty,
  input  logic         load,
  output logic         load_ack,
  output logic         pwm_out
`ifdef PWM_DONE_PULSE_EN
  ,
  output logic         period_done
`endif
);

  logic [W-1:0] cnt;
  logic [W-1:0] period_act;
  logic [W-1:0] duty_act;
  logic [W-1:0] period_pend;
  logic [W-1:0] duty_pend;
  logic         pend_valid;
  logic         tick;
  logic         wrap;
  logic         apply;

  tick_sel_edge u_tick_sel_edge (
    .clk       (clk),
    .rst       (rst),
    .divideby2 (divideby2),
    .divideby4 (divideby4),
    .divideby8 (divideby8),
    .div_sel   (div_sel),
    .tick      (tick)
  );

  // Pending values go live at a wrap, or straight away while the generator is idle.
  always_comb begin
    wrap  = en & tick & (cnt == period_act);
    apply = pend_valid & (wrap | ~en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      period_act  <= W'(DEF_PERIOD);
      duty_act    <= W'(DEF_DUTY);
      period_pend <= '0;
      duty_pend   <= '0;
      pend_valid  <= 1'b0;
      load_ack    <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      if (!en) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= wrap ? '0 : cnt + W'(1);
      end
      if (apply) begin
        period_act <= period_pend;
        duty_act   <= duty_pend;
      end
      // A load coinciding with an apply lands after the old pending copy was consumed.
      if (load) begin
        period_pend <= period;
        duty_pend   <= duty;
      end
      pend_valid <= load | (pend_valid & ~apply);
      load_ack   <= apply;
      pwm_out    <= en & (cnt < duty_act);
    end
  end

`ifdef PWM_DONE_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      period_done <= 1'b0;
    end else begin
      period_done <= wrap;
    end
  end
`endif

endmodule
